// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered immediate generator for the RV32I/RV64I decode stage. Each
// accepted instruction is decoded into an immediate, a format tag, an illegal
// flag and a precomputed pc+imm target. The result is stored in a 2-entry
// valid/ready skid buffer, so decode can stall without a combinational ready
// path back to fetch.
//
// Parameters:
//   XLEN          datapath width (32 or 64)
//   ZEXT_SPECIAL  1: shift-immediate and CSR-immediate forms decode as
//                 zero-extended fields (fmt Z); 0: they decode as I-type
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous flush, drops buffer contents and any input
//   in_valid_i   upstream holds a valid instruction
//   in_ready_o   block can accept this cycle (registered)
//   inst_i       raw 32-bit instruction word
//   pc_i         pc of inst_i
//   out_valid_o  output entry valid
//   out_ready_i  downstream accepts
//   imm_o        decoded immediate
//   fmt_o        R=0 I=1 S=2 B=3 U=4 J=5 Z=6 X=7
//   illegal_o    opcode not in the supported map
//   target_o     pc + imm, modulo 2^XLEN
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter bit ZEXT_SPECIAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] target_o
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;
  localparam logic [2:0] FMT_X = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [31:0]     w_raw;
  logic            w_useSext;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  entry_t          w_newEntry;

  logic [1:0]      r_count;
  logic            r_inReady;
  entry_t          r_entry0;
  entry_t          r_entry1;

  logic            w_accept;
  logic            w_retire;
  logic [1:0]      w_countNext;

  assign w_opcode = inst_i[6:0];
  assign w_funct3 = inst_i[14:12];

  // Decode: every sign-extended format is first assembled as a 32-bit value
  // whose bit 31 is inst[31], so one signed cast covers the extension to XLEN.
  // Zero-extended and R/X results bypass that path.
  always_comb begin
    w_raw     = '0;
    w_useSext = 1'b0;
    w_imm     = '0;
    w_fmt     = FMT_X;
    w_illegal = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      w_fmt     = FMT_X;
      w_illegal = 1'b1;
    end else begin
      unique case (w_opcode)
        OP_LUI, OP_AUIPC: begin
          w_fmt     = FMT_U;
          w_raw     = {inst_i[31:12], 12'b0};
          w_useSext = 1'b1;
        end
        OP_JAL: begin
          w_fmt     = FMT_J;
          w_raw     = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                       inst_i[20], inst_i[30:21], 1'b0};
          w_useSext = 1'b1;
        end
        OP_BRANCH: begin
          w_fmt     = FMT_B;
          w_raw     = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                       inst_i[30:25], inst_i[11:8], 1'b0};
          w_useSext = 1'b1;
        end
        OP_STORE: begin
          w_fmt     = FMT_S;
          w_raw     = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
          w_useSext = 1'b1;
        end
        OP_LOAD, OP_JALR: begin
          w_fmt     = FMT_I;
          w_raw     = {{20{inst_i[31]}}, inst_i[31:20]};
          w_useSext = 1'b1;
        end
        OP_OPIMM: begin
          // Shift amounts are 5 bits on RV32 and 6 bits on RV64; the upper
          // immediate bits carry funct7 and must not leak into the value.
          if (ZEXT_SPECIAL && (w_funct3 == 3'b001 || w_funct3 == 3'b101)) begin
            w_fmt = FMT_Z;
            if (XLEN == 64) begin
              w_imm = XLEN'(inst_i[25:20]);
            end else begin
              w_imm = XLEN'(inst_i[24:20]);
            end
          end else begin
            w_fmt     = FMT_I;
            w_raw     = {{20{inst_i[31]}}, inst_i[31:20]};
            w_useSext = 1'b1;
          end
        end
        OP_SYSTEM: begin
          // CSR immediate forms carry the unsigned zimm in the rs1 field.
          if (ZEXT_SPECIAL && w_funct3[2]) begin
            w_fmt = FMT_Z;
            w_imm = XLEN'(inst_i[19:15]);
          end else begin
            w_fmt     = FMT_I;
            w_raw     = {{20{inst_i[31]}}, inst_i[31:20]};
            w_useSext = 1'b1;
          end
        end
        OP_OP: begin
          w_fmt = FMT_R;
        end
        default: begin
          w_fmt     = FMT_X;
          w_illegal = 1'b1;
        end
      endcase
    end
    if (w_useSext) begin
      w_imm = XLEN'($signed(w_raw));
    end
  end

  // The target adder runs for every format; carry-out is simply dropped.
  always_comb begin
    w_newEntry         = '0;
    w_newEntry.imm     = w_imm;
    w_newEntry.target  = pc_i + w_imm;
    w_newEntry.fmt     = w_fmt;
    w_newEntry.illegal = w_illegal;
  end

  assign in_ready_o  = r_inReady;
  assign out_valid_o = (r_count != 2'd0);
  assign w_accept    = in_valid_i & r_inReady;
  assign w_retire    = out_valid_o & out_ready_i;

  // Occupancy update. Flush wins over any handshake in the same cycle.
  always_comb begin
    w_countNext = r_count;
    if (flush_i) begin
      w_countNext = 2'd0;
    end else if (w_accept && !w_retire) begin
      w_countNext = r_count + 2'd1;
    end else if (!w_accept && w_retire) begin
      w_countNext = r_count - 2'd1;
    end
  end

  // Buffer storage. entry0 always feeds the outputs, entry1 is the skid
  // slot. Ready is registered from the next occupancy so that it never
  // depends combinationally on out_ready_i, and it comes out of reset low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count   <= 2'd0;
      r_inReady <= 1'b0;
      r_entry0  <= '0;
      r_entry1  <= '0;
    end else begin
      r_count   <= w_countNext;
      r_inReady <= (w_countNext != 2'd2);
      if (!flush_i) begin
        if (w_accept && !w_retire) begin
          if (r_count == 2'd0) begin
            r_entry0 <= w_newEntry;
          end else begin
            r_entry1 <= w_newEntry;
          end
        end else if (!w_accept && w_retire) begin
          r_entry0 <= r_entry1;
        end else if (w_accept && w_retire) begin
          if (r_count == 2'd2) begin
            r_entry0 <= r_entry1;
            r_entry1 <= w_newEntry;
          end else begin
            r_entry0 <= w_newEntry;
          end
        end
      end
    end
  end

  assign imm_o     = r_entry0.imm;
  assign target_o  = r_entry0.target;
  assign fmt_o     = r_entry0.fmt;
  assign illegal_o = r_entry0.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. Two instances share the control and
// instruction inputs: a 32-bit one with zero-extended special forms and a
// 64-bit one with them disabled, so both widths and both decode modes of
// each vector are exercised together.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [63:0] pc64;

  logic        inReady;
  logic        outValid;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;
  logic [31:0] target;

  logic        inReady64;
  logic        outValid64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        illegal64;
  logic [63:0] target64;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign pc64 = {32'h0, pc};

  imm_gen_pipe #(.XLEN(32), .ZEXT_SPECIAL(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReady),
    .inst_i(inst), .pc_i(pc),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .imm_o(imm), .fmt_o(fmt), .illegal_o(illegal), .target_o(target)
  );

  imm_gen_pipe #(.XLEN(64), .ZEXT_SPECIAL(1'b0)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(inValid), .in_ready_o(inReady64),
    .inst_i(inst), .pc_i(pc64),
    .out_valid_o(outValid64), .out_ready_i(outReady),
    .imm_o(imm64), .fmt_o(fmt64), .illegal_o(illegal64), .target_o(target64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one instruction for a single edge; called and returns at negedge.
  task automatic applyStimulus(input logic [31:0] word, input logic [31:0] addr);
    inValid = 1'b1;
    inst    = word;
    pc      = addr;
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic checkDecode(input string tag,
                             input logic [2:0] eFmt, input logic [31:0] eImm,
                             input logic [31:0] eTgt, input logic eIll,
                             input logic [2:0] eFmt64, input logic [63:0] eImm64,
                             input logic [63:0] eTgt64);
    checkOutput({tag, ".valid"}, 64'(outValid), 64'd1);
    checkOutput({tag, ".fmt"}, 64'(fmt), 64'(eFmt));
    checkOutput({tag, ".imm"}, 64'(imm), 64'(eImm));
    checkOutput({tag, ".target"}, 64'(target), 64'(eTgt));
    checkOutput({tag, ".illegal"}, 64'(illegal), 64'(eIll));
    checkOutput({tag, ".valid64"}, 64'(outValid64), 64'd1);
    checkOutput({tag, ".fmt64"}, 64'(fmt64), 64'(eFmt64));
    checkOutput({tag, ".imm64"}, imm64, eImm64);
    checkOutput({tag, ".target64"}, target64, eTgt64);
    checkOutput({tag, ".illegal64"}, 64'(illegal64), 64'(eIll));
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    inst     = 32'h0;
    pc       = 32'h0;

    // Reset values
    #2;
    checkOutput("rst.valid", 64'(outValid), 64'd0);
    checkOutput("rst.imm", 64'(imm), 64'd0);
    checkOutput("rst.target", 64'(target), 64'd0);
    checkOutput("rst.fmt", 64'(fmt), 64'd0);
    checkOutput("rst.illegal", 64'(illegal), 64'd0);
    checkOutput("rst.ready", 64'(inReady), 64'd0);
    @(negedge clk);
    checkOutput("rst.readyHeld", 64'(inReady), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst.readyAfterDeassert", 64'(inReady), 64'd0);
    @(negedge clk);
    checkOutput("rst.readyFirstEdge", 64'(inReady), 64'd1);
    checkOutput("rst.readyFirstEdge64", 64'(inReady64), 64'd1);
    checkOutput("rst.validFirstEdge", 64'(outValid), 64'd0);

    // Decode vectors, streamed with downstream always ready
    outReady = 1'b1;
    applyStimulus(32'h0080006F, 32'h100);
    checkDecode("jal", 3'd5, 32'h8, 32'h108, 1'b0, 3'd5, 64'h8, 64'h108);
    applyStimulus(32'hFE000EE3, 32'h200);
    checkDecode("beq", 3'd3, 32'hFFFFFFFC, 32'h1FC, 1'b0,
                3'd3, 64'hFFFFFFFFFFFFFFFC, 64'h1FC);
    applyStimulus(32'hFE000EE3, 32'h0);
    checkDecode("beqWrap", 3'd3, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0,
                3'd3, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    applyStimulus(32'h123450B7, 32'h40);
    checkDecode("lui", 3'd4, 32'h12345000, 32'h12345040, 1'b0,
                3'd4, 64'h12345000, 64'h12345040);
    applyStimulus(32'h800000B7, 32'h0);
    checkDecode("luiNeg", 3'd4, 32'h80000000, 32'h80000000, 1'b0,
                3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000);
    applyStimulus(32'hFFFFF117, 32'h2000);
    checkDecode("auipc", 3'd4, 32'hFFFFF000, 32'h1000, 1'b0,
                3'd4, 64'hFFFFFFFFFFFFF000, 64'h1000);
    applyStimulus(32'h4030D093, 32'h10);
    checkDecode("srai", 3'd6, 32'h3, 32'h13, 1'b0, 3'd1, 64'h403, 64'h413);
    applyStimulus(32'h3002D0F3, 32'h20);
    checkDecode("csrrwi", 3'd6, 32'h5, 32'h25, 1'b0, 3'd1, 64'h300, 64'h320);
    applyStimulus(32'hFE512E23, 32'h300);
    checkDecode("sw", 3'd2, 32'hFFFFFFFC, 32'h2FC, 1'b0,
                3'd2, 64'hFFFFFFFFFFFFFFFC, 64'h2FC);
    applyStimulus(32'hFFC12083, 32'h400);
    checkDecode("lw", 3'd1, 32'hFFFFFFFC, 32'h3FC, 1'b0,
                3'd1, 64'hFFFFFFFFFFFFFFFC, 64'h3FC);
    applyStimulus(32'h00008067, 32'h800);
    checkDecode("jalr", 3'd1, 32'h0, 32'h800, 1'b0, 3'd1, 64'h0, 64'h800);
    applyStimulus(32'h002081B3, 32'h500);
    checkDecode("add", 3'd0, 32'h0, 32'h500, 1'b0, 3'd0, 64'h0, 64'h500);
    applyStimulus(32'h00000000, 32'h600);
    checkDecode("zeroWord", 3'd7, 32'h0, 32'h600, 1'b1, 3'd7, 64'h0, 64'h600);
    applyStimulus(32'h0000007F, 32'h700);
    checkDecode("badOpcode", 3'd7, 32'h0, 32'h700, 1'b1, 3'd7, 64'h0, 64'h700);
    @(negedge clk);
    checkOutput("drain.valid", 64'(outValid), 64'd0);

    // Backpressure: four ADDI x1,x0,k (k=1..4) with downstream stalled
    outReady = 1'b0;
    inValid  = 1'b1;
    pc       = 32'h1000;
    inst     = 32'h00100093;
    @(negedge clk);
    checkOutput("bp.firstValid", 64'(outValid), 64'd1);
    checkOutput("bp.firstImm", 64'(imm), 64'd1);
    checkOutput("bp.readyAfter1", 64'(inReady), 64'd1);
    inst = 32'h00200093;
    @(negedge clk);
    checkOutput("bp.readyAfter2", 64'(inReady), 64'd0);
    checkOutput("bp.holdImm", 64'(imm), 64'd1);
    inst = 32'h00300093;
    @(negedge clk);
    checkOutput("bp.stallImm", 64'(imm), 64'd1);
    checkOutput("bp.stallTarget", 64'(target), 64'h1001);
    checkOutput("bp.stallFmt", 64'(fmt), 64'd1);
    checkOutput("bp.stallImm64", imm64, 64'd1);
    checkOutput("bp.stallReady", 64'(inReady), 64'd0);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("bp.out2Imm", 64'(imm), 64'd2);
    checkOutput("bp.out2Target", 64'(target), 64'h1002);
    checkOutput("bp.readyReopen", 64'(inReady), 64'd1);
    @(negedge clk);
    checkOutput("bp.out3Imm", 64'(imm), 64'd3);
    checkOutput("bp.out3Valid", 64'(outValid), 64'd1);
    checkOutput("bp.sameCycleReady", 64'(inReady), 64'd1);
    inst = 32'h00400093;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("bp.out4Imm", 64'(imm), 64'd4);
    checkOutput("bp.out4Valid", 64'(outValid), 64'd1);
    @(negedge clk);
    checkOutput("bp.emptyValid", 64'(outValid), 64'd0);

    // Flush with one entry held and a new input presented
    outReady = 1'b0;
    applyStimulus(32'h00100093, 32'h1000);
    checkOutput("fl1.loaded", 64'(outValid), 64'd1);
    flush   = 1'b1;
    inValid = 1'b1;
    inst    = 32'h00500093;
    @(negedge clk);
    flush   = 1'b0;
    inValid = 1'b0;
    checkOutput("fl1.valid", 64'(outValid), 64'd0);
    checkOutput("fl1.ready", 64'(inReady), 64'd1);
    @(negedge clk);
    checkOutput("fl1.stillEmpty", 64'(outValid), 64'd0);

    // Flush with both entries held
    inValid = 1'b1;
    inst    = 32'h00100093;
    @(negedge clk);
    inst = 32'h00200093;
    @(negedge clk);
    checkOutput("fl2.full", 64'(inReady), 64'd0);
    flush = 1'b1;
    inst  = 32'h00500093;
    @(negedge clk);
    flush   = 1'b0;
    inValid = 1'b0;
    checkOutput("fl2.valid", 64'(outValid), 64'd0);
    checkOutput("fl2.ready", 64'(inReady), 64'd1);
    outReady = 1'b1;
    applyStimulus(32'h00600093, 32'h1000);
    checkOutput("fl2.nextImm", 64'(imm), 64'd6);
    checkOutput("fl2.nextTarget", 64'(target), 64'h1006);
    @(negedge clk);
    checkOutput("fl2.noGhost", 64'(outValid), 64'd0);

    // Asynchronous reset in the middle of a stalled stream
    outReady = 1'b0;
    inValid  = 1'b1;
    inst     = 32'h00100093;
    @(negedge clk);
    inst = 32'h00200093;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("mr.preImm", 64'(imm), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mr.valid", 64'(outValid), 64'd0);
    checkOutput("mr.imm", 64'(imm), 64'd0);
    checkOutput("mr.target", 64'(target), 64'd0);
    checkOutput("mr.fmt", 64'(fmt), 64'd0);
    checkOutput("mr.ready", 64'(inReady), 64'd0);
    checkOutput("mr.imm64", imm64, 64'd0);
    @(negedge clk);
    checkOutput("mr.readyHeld", 64'(inReady), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("mr.readyAfterDeassert", 64'(inReady), 64'd0);
    @(negedge clk);
    checkOutput("mr.readyFirstEdge", 64'(inReady), 64'd1);
    checkOutput("mr.validFirstEdge", 64'(outValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
